// File: rtl/pokey_cell2pr.sv
// Single-bit POKEY storage cell: synchronous reset/preset/load/hold, advanced only on
// slow-clock enable strobes. Between strobes the flop recirculates.
module pokey_cell2pr #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic D,
    input  logic Ld,
    input  logic nLd,
    input  logic P,
    input  logic R,
    output logic Q
);

    logic q_q;
    logic q_d;

    // R beats P beats Ld; nLd alone and Ld=nLd=0 both retain the stored value.
    always_comb begin
        q_d = q_q;
        if (en) begin
            if (R) begin
                q_d = 1'b0;
            end else if (P) begin
                q_d = 1'b1;
            end else if (Ld) begin
                q_d = D;
            end else if (nLd) begin
                q_d = q_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_pokey_cell2pr.sv
// Bench for pokey_cell2pr: directed slow-period scenarios plus randomized strobes and
// asynchronous resets, every cycle compared against a priority-table model.
module tb_pokey_cell2pr;

    localparam logic RST_VAL = 1'b0;
    localparam int unsigned SLOW_DIV = 28;

    logic clk = 1'b0;
    logic nRst, en, D, Ld, nLd, P, R;
    logic Q;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_on = 1'b0;
    logic m_q = RST_VAL;

    pokey_cell2pr #(.RST_VAL(RST_VAL)) dut (
        .clk  (clk),
        .nRst (nRst),
        .en   (en),
        .D    (D),
        .Ld   (Ld),
        .nLd  (nLd),
        .P    (P),
        .R    (R),
        .Q    (Q)
    );

    always #10 clk = ~clk;

    // Reference: on a strobe, the first asserted control of {R, P, Ld} decides; else keep.
    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_q = RST_VAL;
        end else if (en) begin
            casez ({R, P, Ld})
                3'b1??:  m_q = 1'b0;
                3'b01?:  m_q = 1'b1;
                3'b001:  m_q = D;
                default: m_q = m_q;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            n_tests++;
            if (Q !== m_q) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: Q=%b expected %b", $time, Q, m_q);
            end
        end
    end

    task automatic check_lit(input string name, input logic exp);
        #2;
        n_tests++;
        if (Q !== exp) begin
            n_fail++;
            $display("FAIL %s: Q=%b expected %b", name, Q, exp);
        end
    endtask

    // One slow period: a single-cycle strobe followed by SLOW_DIV-1 quiet cycles.
    task automatic slow_period();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (SLOW_DIV - 2) @(negedge clk);
    endtask

    initial begin
        nRst = 1'b1; en = 1'b0; D = 1'b1; Ld = 1'b1; nLd = 1'b0; P = 1'b0; R = 1'b0;
        #5 nRst = 1'b0;
        check_on = 1'b1;

        // Reset dominates a load with strobes running.
        slow_period();
        slow_period();
        check_lit("reset_hold", 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        repeat (10) @(negedge clk);
        check_lit("post_reset_no_strobe", 1'b0);

        // Load 1, then hold across ~5 us of strobes.
        slow_period();
        check_lit("load1", 1'b1);
        Ld = 1'b0; nLd = 1'b1;
        repeat (9) slow_period();
        check_lit("load1_hold", 1'b1);

        // Synchronous reset.
        R = 1'b1;
        slow_period();
        check_lit("sync_reset", 1'b0);
        R = 1'b0;
        repeat (2) slow_period();
        check_lit("sync_reset_hold", 1'b0);

        // Preset.
        P = 1'b1;
        slow_period();
        check_lit("preset", 1'b1);
        P = 1'b0;
        repeat (2) slow_period();
        check_lit("preset_hold", 1'b1);

        // Load 0, then D toggling with Ld low has no effect.
        D = 1'b0; Ld = 1'b1; nLd = 1'b0;
        slow_period();
        check_lit("load0", 1'b0);
        Ld = 1'b0; nLd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            D = ~D;
            slow_period();
        end
        check_lit("load0_d_toggle", 1'b0);

        // Ld and nLd both high: Ld wins.
        D = 1'b1; Ld = 1'b1; nLd = 1'b1;
        slow_period();
        check_lit("ld_over_nld", 1'b1);

        // Ld = nLd = 0 retains the value.
        D = 1'b0; Ld = 1'b0; nLd = 1'b0;
        slow_period();
        check_lit("dynamic_retain", 1'b1);

        // R and P together from Q=1: R wins.
        R = 1'b1; P = 1'b1;
        slow_period();
        check_lit("r_over_p", 1'b0);

        // All of R, P, Ld with D=1: still 0.
        R = 1'b1; P = 1'b1; Ld = 1'b1; D = 1'b1;
        slow_period();
        check_lit("r_p_ld", 1'b0);
        R = 1'b0; P = 1'b0; Ld = 1'b0; nLd = 1'b1;

        // Controls pulsed only between strobes are never seen.
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        P = 1'b1; Ld = 1'b1;
        repeat (10) @(negedge clk);
        P = 1'b0; Ld = 1'b0;
        repeat (5) @(negedge clk);
        check_lit("gated_between_strobes", 1'b0);
        slow_period();
        check_lit("gated_next_strobe", 1'b0);

        // Async reset coinciding with a strobe that would preset.
        P = 1'b1;
        slow_period();
        check_lit("preset_before_async", 1'b1);
        @(negedge clk);
        en = 1'b1;
        #3 nRst = 1'b0;
        @(negedge clk);
        en = 1'b0;
        check_lit("async_vs_strobe", 1'b0);
        #1 nRst = 1'b1;
        P = 1'b0;
        slow_period();
        check_lit("after_async_hold", 1'b0);
        P = 1'b1;
        slow_period();
        check_lit("after_async_resume", 1'b1);
        P = 1'b0;

        // Randomized phase: dense random strobes, controls and occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) == 0);
            D   = 1'($urandom);
            Ld  = 1'($urandom);
            nLd = 1'($urandom);
            P   = ($urandom_range(0, 5) == 0);
            R   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #3 nRst = 1'b0;
                @(negedge clk);
                #3 nRst = 1'b1;
            end
        end

        @(negedge clk);
        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
